div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing front-end for the iterative integer divider core (`int_div`) in the ALU. It accepts RV32M DIV/DIVU/REM/REMU requests from the execute stage over a valid/ready handshake and resolves divide-by-zero and signed overflow itself. All other requests are converted to unsigned magnitudes, the core is launched, its result is sign-corrected, and the result is held until the writeback side accepts it.

## Interface
- TAG_W, 5, width of the destination-register tag carried with each request
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- i_a  in  32  dividend (rs1)
- i_b  in  32  divisor (rs2)
- i_tag  in  TAG_W  destination tag
- i_flush  in  1  abort in-flight request (pipeline kill)
- o_core_valid  out  1  one-cycle start pulse to core
- o_core_a  out  32  unsigned dividend magnitude, stable while core busy
- o_core_b  out  32  unsigned divisor magnitude, stable while core busy
- i_core_valid  in  1  one-cycle core done pulse
- i_core_quotient  in  32  unsigned quotient
- i_core_remainder  in  32  unsigned remainder
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts when o_valid && i_ready
- o_result  out  32  final result
- o_tag  out  TAG_W  tag of o_result

## Operation
- States: IDLE, START, WAIT, RESP, DRAIN. Reset: state IDLE; o_ready 1; o_valid, o_core_valid 0; o_result, o_tag, o_core_a, o_core_b 0.
- o_ready = 1 only in IDLE. On accept, latch op, tag, and operand signs. signed = ~i_op[0]; sa = signed & i_a[31]; sb = signed & i_b[31].
- Special cases on accept: go straight to RESP with o_result set:
  - b == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give i_a.
  - DIV with a = 0x80000000, b = 0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
- Normal case: o_core_a = sa ? -i_a : i_a; o_core_b = sb ? -i_b : i_b. Both are 32-bit unsigned, so |0x80000000| = 0x80000000. Go to START.
- START: o_core_valid = 1 for exactly one cycle, then WAIT.
- WAIT: on i_core_valid, compute the result and go to RESP:
  - DIV/DIVU: q = i_core_quotient, negated if sa ^ sb.
  - REM/REMU: r = i_core_remainder, negated if sa. The remainder takes the dividend's sign.
  - Negation is 32-bit two's complement, mod 2^32.
- RESP: o_valid = 1. o_result and o_tag are held stable until i_ready. On i_ready, go to IDLE.
- i_flush:
  - In START: suppress the pulse, go to IDLE.
  - In WAIT: go to DRAIN. DRAIN keeps o_ready = 0 and goes to IDLE on i_core_valid; the core result is discarded.
  - In RESP: drop o_valid, go to IDLE.
  - In IDLE: ignored; a request presented in the same cycle is not accepted.
  - In DRAIN: no effect.
- i_core_valid outside WAIT/DRAIN is ignored.

## Timing
- Accept at edge N.
  - Special case: o_valid high from cycle N+1.
  - Normal case: o_core_valid high in cycle N+1. Core done pulse in cycle M gives o_valid high in cycle M+1.
- Throughput: one request in flight. After a result handshake at edge R, o_ready = 1 in cycle R+1, so there is a minimum of one idle cycle between results.
- o_valid and o_result are registered outputs. o_ready and o_core_valid are state decodes with no combinational path from inputs.
- Async reset mid-operation returns all outputs to reset values immediately. A core done pulse arriving after reset is ignored (IDLE).

## Test plan
- DIV a = -7 (0xFFFFFFF9), b = 2; core modeled with 32-cycle latency -> core sees a = 7, b = 2; o_result = 0xFFFFFFFD (-3), o_valid at done+1.
- REM a = -7, b = 2 -> o_result = 0xFFFFFFFF (-1). REMU a = 0xFFFFFFF9, b = 2 -> core sees unchanged operands; o_result = 1.
- DIVU a = 5, b = 0 -> 0xFFFFFFFF at N+1 with no o_core_valid pulse. REM a = 5, b = 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; no core pulse in either case.
- Hold i_ready = 0 for 5 cycles in RESP -> o_result and o_tag stable, o_ready = 0; handshake, then o_ready = 1 next cycle.
- i_flush 3 cycles after the core start -> DRAIN, o_ready = 0 until i_core_valid, no o_valid. A following DIV 100/7 returns 14. Repeat the sequence with i_rst_n asserted mid-WAIT -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequencing front-end for the iterative integer divider core: handles RV32M
// special cases locally, feeds the core unsigned magnitudes and sign-corrects its result.
module div_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_core_valid,
    output logic [31:0]      o_core_a,
    output logic [31:0]      o_core_b,
    input  logic             i_core_valid,
    input  logic [31:0]      i_core_quotient,
    input  logic [31:0]      i_core_remainder,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag
);

    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

    state_t      state;
    logic        is_rem_q;
    logic        sa_q;
    logic        sb_q;

    logic        is_signed;
    logic        sa;
    logic        sb;
    logic        special;
    logic [31:0] special_result;
    logic [31:0] core_result;

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        is_signed      = ~i_op[0];
        sa             = is_signed & i_a[31];
        sb             = is_signed & i_b[31];
        special        = 1'b0;
        special_result = '0;
        if (i_b == '0) begin
            special        = 1'b1;
            special_result = i_op[1] ? i_a : 32'hFFFF_FFFF;
        end else if (is_signed && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF) begin
            special        = 1'b1;
            special_result = i_op[1] ? 32'h0 : 32'h8000_0000;
        end

        // Remainder follows the dividend's sign; quotient is negative when signs differ.
        core_result = '0;
        if (is_rem_q)
            core_result = sa_q ? -i_core_remainder : i_core_remainder;
        else
            core_result = (sa_q ^ sb_q) ? -i_core_quotient : i_core_quotient;
    end

    assign o_ready      = (state == IDLE);
    assign o_core_valid = (state == START);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            is_rem_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            o_core_a <= '0;
            o_core_b <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && !i_flush) begin
                        is_rem_q <= i_op[1];
                        sa_q     <= sa;
                        sb_q     <= sb;
                        o_tag    <= i_tag;
                        if (special) begin
                            o_result <= special_result;
                            o_valid  <= 1'b1;
                            state    <= RESP;
                        end else begin
                            o_core_a <= sa ? -i_a : i_a;
                            o_core_b <= sb ? -i_b : i_b;
                            state    <= START;
                        end
                    end
                end
                START: begin
                    state <= i_flush ? IDLE : WAIT;
                end
                WAIT: begin
                    // A done pulse coinciding with the flush has nothing left to drain.
                    if (i_flush) begin
                        state <= i_core_valid ? IDLE : DRAIN;
                    end else if (i_core_valid) begin
                        o_result <= core_result;
                        o_valid  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (i_flush || i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (i_core_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a latency-programmable divider core model plus
// a reference model computing RV32M results with plain 64-bit arithmetic.
module tb_div_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_tag;
    logic        i_flush;
    logic        o_core_valid;
    logic [31:0] o_core_a;
    logic [31:0] o_core_b;
    logic        i_core_valid;
    logic [31:0] i_core_quotient;
    logic [31:0] i_core_remainder;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Core model state
    int          core_lat = 32;
    int          core_cnt = 0;
    bit          core_busy = 0;
    int          core_starts = 0;
    int          done_cyc = -1;
    logic [31:0] core_a_seen;
    logic [31:0] core_b_seen;

    div_ctrl #(.TAG_W(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .i_flush(i_flush),
        .o_core_valid(o_core_valid), .o_core_a(o_core_a), .o_core_b(o_core_b),
        .i_core_valid(i_core_valid), .i_core_quotient(i_core_quotient),
        .i_core_remainder(i_core_remainder), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_tag(o_tag)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Core model: samples the start pulse and answers core_lat cycles later.
    always @(negedge i_clk) begin
        i_core_valid = 1'b0;
        if (core_busy) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
                i_core_valid     = 1'b1;
                i_core_quotient  = (core_b_seen == 0) ? 32'hFFFF_FFFF : core_a_seen / core_b_seen;
                i_core_remainder = (core_b_seen == 0) ? core_a_seen : core_a_seen % core_b_seen;
                done_cyc         = cyc;
                core_busy        = 0;
            end
        end
        if (o_core_valid) begin
            core_a_seen = o_core_a;
            core_b_seen = o_core_b;
            core_cnt    = core_lat;
            core_busy   = 1;
            core_starts = core_starts + 1;
        end
    end

    function automatic longint to_num(input logic [31:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'({32'b0, v});
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        x = to_num(a, !op[0]);
        y = to_num(b, !op[0]);
        q = x / y;
        r = x % y;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] v, input bit sgn);
        longint x;
        x = to_num(v, sgn);
        if (x < 0) x = -x;
        return x[31:0];
    endfunction

    function automatic bit ref_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Presents a request at a negedge, lets it be accepted, ends one negedge later.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: o_ready=%b required 1", o_ready);
        end
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_tag = tag;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_core_idle();
        for (int i = 0; i < 200 && core_busy; i++) @(negedge i_clk);
        checks++;
        if (core_busy) begin
            errors++;
            $display("FAIL core_idle_timeout: core model still busy required idle");
        end
    endtask

    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input int lat, input int rdy_delay);
        logic [31:0] exp_res;
        bit          spec;
        int          starts0;
        bit          got;
        exp_res  = ref_result(op, a, b);
        spec     = ref_special(op, a, b);
        starts0  = core_starts;
        core_lat = lat;
        issue(op, a, b, tag);
        if (spec) begin
            checks++;
            if (o_valid !== 1'b1) begin
                errors++;
                $display("FAIL special_latency: o_valid=%b required 1 at N+1", o_valid);
            end
        end else begin
            checks++;
            if (o_core_valid !== 1'b1 || o_core_a !== ref_mag(a, !op[0]) || o_core_b !== ref_mag(b, !op[0])) begin
                errors++;
                $display("FAIL core_launch: pulse=%b a=%h b=%h required 1 %h %h",
                         o_core_valid, o_core_a, o_core_b, ref_mag(a, !op[0]), ref_mag(b, !op[0]));
            end
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                if (o_valid === 1'b1) got = 1;
                else @(negedge i_clk);
            end
            checks++;
            if (!got || cyc != done_cyc + 1) begin
                errors++;
                $display("FAIL result_latency: valid=%b cycle=%0d required valid at cycle %0d", got, cyc, done_cyc + 1);
            end
        end
        checks++;
        if (o_result !== exp_res || o_tag !== tag) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: got %h tag %0d required %h tag %0d",
                     op, a, b, o_result, o_tag, exp_res, tag);
        end
        checks++;
        if (core_starts != starts0 + (spec ? 0 : 1)) begin
            errors++;
            $display("FAIL core_start_count: got %0d required %0d", core_starts - starts0, spec ? 0 : 1);
        end
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== exp_res || o_tag !== tag) begin
                errors++;
                $display("FAIL hold: valid=%b ready=%b res=%h tag=%0d required 1 0 %h %0d",
                         o_valid, o_ready, o_result, o_tag, exp_res, tag);
            end
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: ready=%b valid=%b required 1 0", o_ready, o_valid);
        end
        wait_core_idle();
    endtask

    task automatic test_reset();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_core_valid !== 1'b0 || o_result !== 32'h0 ||
            o_tag !== 5'h0 || o_core_a !== 32'h0 || o_core_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b v=%b cv=%b res=%h tag=%h ca=%h cb=%h required 1 0 0 0 0 0 0",
                     o_ready, o_valid, o_core_valid, o_result, o_tag, o_core_a, o_core_b);
        end
    endtask

    task automatic test_directed();
        run_one(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32, 0);
        run_one(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32, 0);
        run_one(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3, 32, 0);
        run_one(2'b01, 32'd5, 32'd0, 5'd4, 32, 0);
        run_one(2'b10, 32'd5, 32'd0, 5'd5, 32, 0);
        run_one(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32, 0);
        run_one(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32, 0);
        run_one(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 5, 0);
    endtask

    task automatic test_backpressure();
        run_one(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd9, 10, 5);
        run_one(2'b11, 32'd77, 32'd0, 5'd10, 10, 5);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = $urandom_range(0, 300);
                    b = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: b = $urandom_range(1, 9);
                default: ;
            endcase
            run_one(2'($urandom_range(0, 3)), a, b, 5'($urandom), $urandom_range(1, 40), $urandom_range(0, 3));
        end
    endtask

    task automatic test_flush_idle();
        int starts0;
        starts0 = core_starts;
        i_flush = 1'b1;
        issue(2'b00, 32'd9, 32'd3, 5'd11);
        i_flush = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_core_valid !== 1'b0 || o_valid !== 1'b0 || core_starts != starts0) begin
            errors++;
            $display("FAIL flush_idle: rdy=%b cv=%b v=%b required 1 0 0", o_ready, o_core_valid, o_valid);
        end
    endtask

    task automatic test_flush_resp();
        issue(2'b00, 32'd9, 32'd0, 5'd12);
        i_flush = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_resp: v=%b rdy=%b required 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_flush_wait();
        int bad;
        core_lat = 32;
        issue(2'b00, 32'd50, 32'd5, 5'd13);
        repeat (3) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 200 && core_busy; i++) begin
            if (o_ready !== 1'b0 || o_valid !== 1'b0) bad++;
            @(negedge i_clk);
        end
        checks++;
        if (bad != 0 || core_busy) begin
            errors++;
            $display("FAIL flush_drain: %0d cycles with ready/valid high, busy=%b required 0 0", bad, core_busy);
        end
        // The done pulse is being sampled at the next edge; DRAIN leaves after it.
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: rdy=%b v=%b required 1 0", o_ready, o_valid);
        end
        run_one(2'b00, 32'd100, 32'd7, 5'd14, 32, 0);
        checks++;
        if (ref_result(2'b00, 32'd100, 32'd7) !== 32'd14) begin
            errors++;
            $display("FAIL ref_100_7: got %0d required 14", ref_result(2'b00, 32'd100, 32'd7));
        end
    endtask

    task automatic test_reset_mid_wait();
        core_lat = 32;
        issue(2'b00, 32'hFFFF_FF00, 32'd3, 5'd15);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_core_valid !== 1'b0 || o_result !== 32'h0 ||
            o_tag !== 5'h0 || o_core_a !== 32'h0 || o_core_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: rdy=%b v=%b cv=%b res=%h tag=%h ca=%h cb=%h required 1 0 0 0 0 0 0",
                     o_ready, o_valid, o_core_valid, o_result, o_tag, o_core_a, o_core_b);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_core_idle();
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_done_ignored: v=%b rdy=%b required 0 1", o_valid, o_ready);
        end
        run_one(2'b00, 32'd100, 32'd7, 5'd16, 32, 0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = 2'b00;
        i_a     = '0;
        i_b     = '0;
        i_tag   = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_core_valid     = 1'b0;
        i_core_quotient  = '0;
        i_core_remainder = '0;
        repeat (3) @(negedge i_clk);
        test_reset();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        test_directed();
        test_backpressure();
        test_flush_idle();
        test_flush_resp();
        test_flush_wait();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
